// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - ID-stage issue and hazard-control signal bundle
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 4,
  parameter int REG_W    = 2,
  parameter int CNT_W    = 3,
  parameter int PERF_W   = 16
);
  logic                issue_valid;
  logic                use_rs;
  logic                use_rt;
  logic [REG_W-1:0]    rs_id;
  logic [REG_W-1:0]    rt_id;
  logic                writes_reg;
  logic [REG_W-1:0]    wr_reg;
  logic [CNT_W-1:0]    wr_lat;
  logic                is_branch;
  logic                is_jump;
  logic                branch_miss;
  logic                stall;
  logic                bubblify;
  logic                flush_if;
  logic                pc_write;
  logic                ir_write;
  logic                incr_num_inst;
  logic [NUM_REGS-1:0] busy;
  logic [PERF_W-1:0]   stall_cycles;
  logic [PERF_W-1:0]   flush_cycles;

  modport master (
    output issue_valid, use_rs, use_rt, rs_id, rt_id, writes_reg, wr_reg, wr_lat,
           is_branch, is_jump, branch_miss,
    input  stall, bubblify, flush_if, pc_write, ir_write, incr_num_inst, busy,
           stall_cycles, flush_cycles
  );

  modport slave (
    input  issue_valid, use_rs, use_rt, rs_id, rt_id, writes_reg, wr_reg, wr_lat,
           is_branch, is_jump, branch_miss,
    output stall, bubblify, flush_if, pc_write, ir_write, incr_num_inst, busy,
           stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - per-register latency scoreboard with stall/flush control
module hazard_scoreboard #(
  parameter int NUM_REGS       = 4,
  parameter int REG_W          = 2,
  parameter int CNT_W          = 3,
  parameter int BRANCH_MODE    = 1,
  parameter int RESOLVE_CYCLES = 2,
  parameter int PERF_W         = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  hazard_scoreboard_if.slave hs
);
  localparam int FW_W = (RESOLVE_CYCLES > 1) ? $clog2(RESOLVE_CYCLES) : 1;
  localparam logic [FW_W-1:0] FW_LOAD = FW_W'(RESOLVE_CYCLES - 1);

  logic [CNT_W-1:0]  cnt [NUM_REGS];
  logic [FW_W-1:0]   fw_cnt;
  logic [FW_W-1:0]   fw_next;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] flush_cnt;

  logic hazard;
  logic accept;
  logic flushing;
  logic stall;
  logic bubblify;
  logic flush_if;
  logic pc_write;
  logic ir_write;

  assign flushing = (fw_cnt != '0);
  assign hazard   = hs.issue_valid &&
                    ((hs.use_rs && (cnt[hs.rs_id] != '0)) ||
                     (hs.use_rt && (cnt[hs.rt_id] != '0)));
  assign accept   = hs.issue_valid && !hazard && !hs.branch_miss && !flushing;

  // Priority: branch_miss > data hazard > open flush window > newly accepted control transfer
  always_comb begin
    stall    = 1'b0;
    bubblify = 1'b0;
    flush_if = 1'b0;
    pc_write = 1'b1;
    ir_write = 1'b1;
    fw_next  = flushing ? (fw_cnt - 1'b1) : fw_cnt;
    if (hs.branch_miss) begin
      flush_if = 1'b1;
      bubblify = 1'b1;
      fw_next  = '0;
    end else if (hazard) begin
      stall    = 1'b1;
      bubblify = 1'b1;
      pc_write = 1'b0;
      ir_write = 1'b0;
    end else if (flushing) begin
      flush_if = 1'b1;
    end else if (accept) begin
      if (BRANCH_MODE == 0) begin
        if (hs.is_branch) begin
          flush_if = 1'b1;
          fw_next  = FW_LOAD;
        end else if (hs.is_jump) begin
          flush_if = 1'b1;
          fw_next  = '0;
        end
      end else if (hs.is_jump) begin
        flush_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < NUM_REGS; r++) cnt[r] <= '0;
      fw_cnt    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      // A fresh load on the destination wins over that register's own decrement
      for (int r = 0; r < NUM_REGS; r++) begin
        if (accept && hs.writes_reg && (hs.wr_reg == REG_W'(r))) begin
          cnt[r] <= hs.wr_lat;
        end else if (cnt[r] != '0) begin
          cnt[r] <= cnt[r] - 1'b1;
        end
      end
      fw_cnt <= fw_next;
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_if && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_busy
    assign hs.busy[g] = (cnt[g] != '0);
  end

  assign hs.stall         = stall;
  assign hs.bubblify      = bubblify;
  assign hs.flush_if      = flush_if;
  assign hs.pc_write      = pc_write;
  assign hs.ir_write      = ir_write;
  assign hs.incr_num_inst = !(bubblify || flush_if);
  assign hs.stall_cycles  = stall_cnt;
  assign hs.flush_cycles  = flush_cnt;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed self-checking bench for hazard_scoreboard
module tb_hazard_scoreboard;
  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  hazard_scoreboard_if #(.NUM_REGS(4), .REG_W(2), .CNT_W(3), .PERF_W(16)) if_a ();
  hazard_scoreboard_if #(.NUM_REGS(4), .REG_W(2), .CNT_W(3), .PERF_W(16)) if_b ();
  hazard_scoreboard_if #(.NUM_REGS(4), .REG_W(2), .CNT_W(3), .PERF_W(2))  if_c ();

  hazard_scoreboard #(.BRANCH_MODE(1), .RESOLVE_CYCLES(2), .PERF_W(16)) u_a (
    .clk(clk), .reset_n(reset_n), .hs(if_a)
  );
  hazard_scoreboard #(.BRANCH_MODE(0), .RESOLVE_CYCLES(2), .PERF_W(16)) u_b (
    .clk(clk), .reset_n(reset_n), .hs(if_b)
  );
  hazard_scoreboard #(.BRANCH_MODE(0), .RESOLVE_CYCLES(3), .PERF_W(2)) u_c (
    .clk(clk), .reset_n(reset_n), .hs(if_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

`define CLR_IF(x) \
    x.issue_valid = 1'b0; x.use_rs = 1'b0; x.use_rt = 1'b0; x.rs_id = '0; x.rt_id = '0; \
    x.writes_reg = 1'b0; x.wr_reg = '0; x.wr_lat = '0; x.is_branch = 1'b0; \
    x.is_jump = 1'b0; x.branch_miss = 1'b0;

  task automatic clear_all();
    `CLR_IF(if_a)
    `CLR_IF(if_b)
    `CLR_IF(if_c)
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    clear_all();
    #2;
    check("rst_busy",      32'(if_a.busy), 0);
    check("rst_stall",     32'(if_a.stall), 0);
    check("rst_flush",     32'(if_a.flush_if), 0);
    check("rst_pc_write",  32'(if_a.pc_write), 1);
    check("rst_stall_cyc", 32'(if_a.stall_cycles), 0);
    check("rst_flush_cyc", 32'(if_a.flush_cycles), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // load-use: r2 lat 1, consumer stalls one cycle
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.writes_reg = 1; if_a.wr_reg = 2; if_a.wr_lat = 1;
    #1 check("lu_producer_stall", 32'(if_a.stall), 0);
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.use_rs = 1; if_a.rs_id = 2;
    #1;
    check("lu_stall",     32'(if_a.stall), 1);
    check("lu_bubblify",  32'(if_a.bubblify), 1);
    check("lu_pc_write",  32'(if_a.pc_write), 0);
    check("lu_ir_write",  32'(if_a.ir_write), 0);
    check("lu_busy",      32'(if_a.busy), 32'h4);
    check("lu_incr",      32'(if_a.incr_num_inst), 0);
    @(negedge clk); #1;
    check("lu_release",   32'(if_a.stall), 0);
    check("lu_pc_resume", 32'(if_a.pc_write), 1);
    check("lu_stall_cyc", 32'(if_a.stall_cycles), 1);
    check("lu_incr_go",   32'(if_a.incr_num_inst), 1);

    // multi-cycle: r1 lat 5, rt consumer stalls five cycles
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.writes_reg = 1; if_a.wr_reg = 1; if_a.wr_lat = 5;
    #1 check("mc_producer_stall", 32'(if_a.stall), 0);
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.use_rt = 1; if_a.rt_id = 1;
    for (int i = 0; i < 5; i++) begin
      #1 check("mc_stall", 32'(if_a.stall), 1);
      @(negedge clk);
    end
    #1;
    check("mc_busy1_clear", 32'(if_a.busy[1]), 0);
    check("mc_release",     32'(if_a.stall), 0);
    check("mc_stall_cyc",   32'(if_a.stall_cycles), 6);

    // branch_miss beats a simultaneous hazard and blocks the load
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.writes_reg = 1; if_a.wr_reg = 3; if_a.wr_lat = 2;
    #1 check("pr_producer_stall", 32'(if_a.stall), 0);
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.use_rs = 1; if_a.rs_id = 3;
    if_a.writes_reg = 1; if_a.wr_reg = 0; if_a.wr_lat = 7; if_a.branch_miss = 1;
    #1;
    check("pr_flush",    32'(if_a.flush_if), 1);
    check("pr_stall",    32'(if_a.stall), 0);
    check("pr_bubblify", 32'(if_a.bubblify), 1);
    check("pr_pc_write", 32'(if_a.pc_write), 1);
    check("pr_incr",     32'(if_a.incr_num_inst), 0);

    // cnt[3]==1 here; reissue r3 with lat 4 must reload, not expire
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.writes_reg = 1; if_a.wr_reg = 3; if_a.wr_lat = 4;
    #1;
    check("pr_no_r0_load", 32'(if_a.busy), 32'h8);
    check("pr_flush_cyc",  32'(if_a.flush_cycles), 1);
    check("ri_accept",     32'(if_a.stall), 0);
    @(negedge clk); clear_all();
    #1 check("ri_busy_cnt4", 32'(if_a.busy), 32'h8);
    repeat (3) @(negedge clk);
    #1 check("ri_busy_cnt1", 32'(if_a.busy), 32'h8);
    @(negedge clk);
    #1 check("ri_busy_done", 32'(if_a.busy), 0);

    // predict-not-taken: jump flushes once, branch never
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.is_jump = 1;
    #1;
    check("pnt_jump_flush", 32'(if_a.flush_if), 1);
    check("pnt_jump_bub",   32'(if_a.bubblify), 0);
    check("pnt_jump_incr",  32'(if_a.incr_num_inst), 0);
    @(negedge clk); clear_all();
    if_a.issue_valid = 1; if_a.is_branch = 1;
    #1;
    check("pnt_br_flush", 32'(if_a.flush_if), 0);
    check("pnt_br_incr",  32'(if_a.incr_num_inst), 1);
    @(negedge clk); clear_all();
    #1 check("pnt_flush_cyc", 32'(if_a.flush_cycles), 2);

    // stall-based branch, RESOLVE_CYCLES=2: two flush cycles, write blocked during window
    @(negedge clk); clear_all();
    if_b.issue_valid = 1; if_b.is_branch = 1;
    #1;
    check("sb_flush0", 32'(if_b.flush_if), 1);
    check("sb_incr0",  32'(if_b.incr_num_inst), 0);
    @(negedge clk); clear_all();
    if_b.issue_valid = 1; if_b.writes_reg = 1; if_b.wr_reg = 1; if_b.wr_lat = 3;
    #1;
    check("sb_flush1", 32'(if_b.flush_if), 1);
    check("sb_bub1",   32'(if_b.bubblify), 0);
    check("sb_incr1",  32'(if_b.incr_num_inst), 0);
    @(negedge clk); clear_all();
    #1;
    check("sb_flush2",    32'(if_b.flush_if), 0);
    check("sb_no_load",   32'(if_b.busy), 0);
    check("sb_flush_cyc", 32'(if_b.flush_cycles), 2);
    @(negedge clk); clear_all();
    if_b.issue_valid = 1; if_b.is_jump = 1;
    #1 check("sb_jump_flush", 32'(if_b.flush_if), 1);
    @(negedge clk); clear_all();
    #1 check("sb_jump_once", 32'(if_b.flush_if), 0);

    // RESOLVE_CYCLES=3: branch_miss cancels the open flush window
    @(negedge clk); clear_all();
    if_c.issue_valid = 1; if_c.is_branch = 1;
    #1 check("fc_flush0", 32'(if_c.flush_if), 1);
    @(negedge clk); clear_all();
    if_c.branch_miss = 1;
    #1;
    check("fc_miss_flush", 32'(if_c.flush_if), 1);
    check("fc_miss_bub",   32'(if_c.bubblify), 1);
    @(negedge clk); clear_all();
    #1;
    check("fc_window_cleared", 32'(if_c.flush_if), 0);
    check("fc_flush_cyc",      32'(if_c.flush_cycles), 2);

    // PERF_W=2: stall counter saturates at 3, then reset mid-stall
    @(negedge clk); clear_all();
    if_c.issue_valid = 1; if_c.writes_reg = 1; if_c.wr_reg = 1; if_c.wr_lat = 7;
    #1 check("sat_producer", 32'(if_c.stall), 0);
    @(negedge clk); clear_all();
    if_c.issue_valid = 1; if_c.use_rs = 1; if_c.rs_id = 1;
    repeat (5) @(negedge clk);
    #1;
    check("sat_still_stall", 32'(if_c.stall), 1);
    check("sat_stall_cyc",   32'(if_c.stall_cycles), 3);
    reset_n = 1'b0;
    #1;
    check("mr_busy",      32'(if_c.busy), 0);
    check("mr_stall",     32'(if_c.stall), 0);
    check("mr_stall_cyc", 32'(if_c.stall_cycles), 0);
    check("mr_flush_cyc", 32'(if_c.flush_cycles), 0);
    check("mr_a_cnt",     32'(if_a.stall_cycles), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk); #1;
    check("mr_no_stall_after", 32'(if_c.stall), 0);
    check("mr_pc_write_after", 32'(if_c.pc_write), 1);
    check("mr_busy_after",     32'(if_c.busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NUM_REGS, default 4: number of architectural registers tracked.
REQ-002 Parameter REG_W, default 2: register-index width, equal to clog2(NUM_REGS).
REQ-003 Parameter CNT_W, default 3: per-register latency-counter width; maximum latency is 2^CNT_W-1.
REQ-004 Parameter BRANCH_MODE, default 1: 0 = stall-based branch resolution, 1 = predict-not-taken.
REQ-005 Parameter RESOLVE_CYCLES, default 2: cycles a branch in ID holds flush_if when BRANCH_MODE=0.
REQ-006 Parameter PERF_W, default 16: width of the performance counters.
REQ-007 Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- issue_valid  in  1  valid instruction in ID.
- use_rs, use_rt  in  1  ID reads rs / rt.
- rs_id, rt_id  in  REG_W  source register indices.
- writes_reg  in  1  ID instruction writes a register.
- wr_reg  in  REG_W  destination register index.
- wr_lat  in  CNT_W  cycles until the result is forwardable; 0 = available to the next instruction.
- is_branch, is_jump  in  1  ID instruction class.
- branch_miss  in  1  EX reports a mispredicted or taken branch.
- stall  out  1  data hazard; hold ID.
- bubblify  out  1  zero the ID/EX control signals.
- flush_if  out  1  replace the IR with a NOP.
- pc_write, ir_write  out  1  PC / IR write enables.
- incr_num_inst  out  1  count a retired-issue slot.
- busy  out  NUM_REGS  bit r = (cnt[r] != 0).
- stall_cycles, flush_cycles  out  PERF_W  saturating performance counters.

Function
REQ-008 Each register r SHALL hold a counter cnt[r] (CNT_W bits); cnt[r]==0 means the value is forwardable.
REQ-009 hazard SHALL be issue_valid && ((use_rs && cnt[rs_id]!=0) || (use_rt && cnt[rt_id]!=0)).
REQ-010 accept SHALL be issue_valid && !hazard && !branch_miss && !flushing.
REQ-011 Each clock, every nonzero cnt[r] SHALL decrement by 1.
REQ-012 On accept with writes_reg=1, cnt[wr_reg] SHALL load wr_lat; this load overrides the decrement of that same register in that cycle.
REQ-013 branch_miss has the highest priority: flush_if=1, bubblify=1, pc_write=1, ir_write=1, stall=0, no counter load, and any pending flush window is cleared.
REQ-014 Else, on hazard: stall=1, bubblify=1, pc_write=0, ir_write=0, flush_if=0.
REQ-015 Else, with BRANCH_MODE=0 and an accepted branch or jump: flush_if=1 for that cycle, and the flush window counter loads RESOLVE_CYCLES-1 (branch) or 0 (jump).
REQ-016 While the flush window counter is nonzero, flushing=1: flush_if=1 and bubblify=0; the counter decrements each cycle.
REQ-017 With BRANCH_MODE=1, an accepted jump SHALL assert flush_if for one cycle; an accepted branch SHALL NOT flush.
REQ-018 Default outputs SHALL be pc_write=1, ir_write=1, stall=0, bubblify=0, flush_if=0.
REQ-019 incr_num_inst SHALL equal !(bubblify || flush_if).
REQ-020 stall_cycles SHALL increment on each cycle with stall=1, saturating at all-ones.
REQ-021 flush_cycles SHALL increment on each cycle with flush_if=1, saturating at all-ones.
REQ-022 All outputs except the counter registers are combinational from the inputs and the current state; there is no added latency.
REQ-023 Register index 0 is tracked like any other register (no hardwired zero).

Reset
REQ-024 While reset_n=0: all cnt[r]=0, the flush window counter is 0, and stall_cycles=flush_cycles=0, asynchronously.
REQ-025 Combinational outputs reflect the reset state: busy=0, and with issue_valid=0, stall=0, flush_if=0, pc_write=1.
REQ-026 Reset asserted mid-stall or mid-flush SHALL abandon the operation; no stall or flush persists after reset_n rises.

Verification
REQ-027 Load-use: accept wr_reg=2, wr_lat=1; next cycle rs_id=2, use_rs=1 -> stall=1 for exactly 1 cycle, then accept; stall_cycles=1.
REQ-028 Multi-cycle: wr_reg=1, wr_lat=5; dependent rt_id=1 -> 5 stall cycles, busy[1]=0 on the 6th cycle.
REQ-029 Priority: hazard and branch_miss in the same cycle -> flush_if=1, stall=0, and no cnt load for the ID instruction.
REQ-030 BRANCH_MODE=0, RESOLVE_CYCLES=2: accepted branch -> flush_if=1 for 2 cycles, incr_num_inst=0 in both, flush_cycles=2.
REQ-031 Same-register reissue: cnt[3]=1 and an accept writing r3 with wr_lat=4 -> cnt[3]=4 next cycle, not 0.
REQ-032 Set PERF_W=2 and stall for 5 cycles -> stall_cycles holds 3; reset_n pulsed low mid-stall -> all counters 0 and busy=0 immediately.
